// File: rtl/pipeline_job_sequencer_pkg.sv
// Shared widths, defaults and state encoding for the pipeline job sequencer.
package pipeline_job_sequencer_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT      = 8;
   localparam int unsigned FULL_THRESHOLD_DEFAULT  = 20;
   localparam int unsigned MAX_OUTSTANDING_DEFAULT = 63;

   localparam int unsigned WORD_WIDTH        = 128;
   localparam int unsigned FULLNESS_WIDTH    = 5;
   localparam int unsigned SUMMED_WIDTH      = 40;
   localparam int unsigned PCOEFF_WIDTH      = 5;
   localparam int unsigned TOTAL_SUM_WIDTH   = 64;
   localparam int unsigned TOTAL_COUNT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } jobState_t;

endpackage

// File: rtl/pipeline_job_sequencer_if.sv
// Job control, bot memory and permutation-pack signals of the sequencer.
interface pipeline_job_sequencer_if
   import pipeline_job_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) ();

   logic                         start;
   logic [WORD_WIDTH-1:0]        jobTop;
   logic [ADDR_WIDTH:0]          botCount;
   logic                         busy;
   logic                         done;
   logic [TOTAL_SUM_WIDTH-1:0]   totalSum;
   logic [TOTAL_COUNT_WIDTH-1:0] totalCount;
   logic                         protocolError;

   logic                         botReadEnable;
   logic [ADDR_WIDTH-1:0]        botReadAddr;
   logic [WORD_WIDTH-1:0]        botReadData;

   logic [WORD_WIDTH-1:0]        top;
   logic [WORD_WIDTH-1:0]        bot;
   logic [ADDR_WIDTH-1:0]        botIndex;
   logic                         isBotValid;
   logic [FULLNESS_WIDTH-1:0]    maxFullness;
   logic                         resultValid;
   logic [SUMMED_WIDTH-1:0]      summedData;
   logic [PCOEFF_WIDTH-1:0]      pcoeffCount;

   modport master (
      input  start, jobTop, botCount, botReadData, maxFullness,
             resultValid, summedData, pcoeffCount,
      output busy, done, totalSum, totalCount, protocolError,
             botReadEnable, botReadAddr, top, bot, botIndex, isBotValid
   );

   modport slave (
      output start, jobTop, botCount, botReadData, maxFullness,
             resultValid, summedData, pcoeffCount,
      input  busy, done, totalSum, totalCount, protocolError,
             botReadEnable, botReadAddr, top, bot, botIndex, isBotValid
   );

endinterface

// File: rtl/pipeline_job_sequencer_accumulator.sv
// Outstanding-bot counter, job totals and sticky protocol error.
module job_result_accumulator
   import pipeline_job_sequencer_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         issue,
   input  logic                         resultValid,
   input  logic [SUMMED_WIDTH-1:0]      summedData,
   input  logic [PCOEFF_WIDTH-1:0]      pcoeffCount,
   output logic [OUT_WIDTH-1:0]         outstanding,
   output logic [TOTAL_SUM_WIDTH-1:0]   totalSum,
   output logic [TOTAL_COUNT_WIDTH-1:0] totalCount,
   output logic                         protocolError
);

   logic noneOutstanding;
   logic accept;

   assign noneOutstanding = (outstanding == '0);
   assign accept          = resultValid && !noneOutstanding;

   // A result with nothing outstanding is flagged and otherwise ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding   <= '0;
         totalSum      <= '0;
         totalCount    <= '0;
         protocolError <= 1'b0;
      end else begin
         if (resultValid && noneOutstanding) begin
            protocolError <= 1'b1;
         end
         if (clear) begin
            outstanding <= issue ? OUT_WIDTH'(1) : '0;
            totalSum    <= '0;
            totalCount  <= '0;
         end else begin
            if (issue && !accept) begin
               outstanding <= outstanding + OUT_WIDTH'(1);
            end else if (!issue && accept) begin
               outstanding <= outstanding - OUT_WIDTH'(1);
            end
            if (accept) begin
               totalSum   <= totalSum + TOTAL_SUM_WIDTH'(summedData);
               totalCount <= totalCount + TOTAL_COUNT_WIDTH'(pcoeffCount);
            end
         end
      end
   end

endmodule

// File: rtl/pipeline_job_sequencer.sv
// Walks a job's bot list into the permutation pack under fullness and
// outstanding-count backpressure, and accumulates the returned results.
module pipeline_job_sequencer
   import pipeline_job_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
   parameter int unsigned FULL_THRESHOLD  = FULL_THRESHOLD_DEFAULT,
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   pipeline_job_sequencer_if.master jobBus
);

   localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   jobState_t               state;
   jobState_t               stateNext;
   logic                    startAccept;
   logic                    issue;
   logic                    fullOk;
   logic                    capOk;
   logic [ADDR_WIDTH:0]     nextIndex;
   logic [ADDR_WIDTH:0]     botCountQ;
   logic [WORD_WIDTH-1:0]   jobTopQ;
   logic                    botReadEnableQ;
   logic [ADDR_WIDTH-1:0]   botReadAddrQ;
   logic                    isBotValidQ;
   logic [ADDR_WIDTH-1:0]   botIndexQ;
   logic                    busyQ;
   logic                    doneQ;
   logic [OUT_WIDTH-1:0]    outstanding;

   assign fullOk = 32'(jobBus.maxFullness) < FULL_THRESHOLD;
   assign capOk  = 32'(outstanding) < MAX_OUTSTANDING;

   // Next state and issue decision; the first read issues on the start edge.
   always_comb begin
      stateNext   = state;
      startAccept = 1'b0;
      issue       = 1'b0;
      case (state)
         IDLE: begin
            if (jobBus.start) begin
               startAccept = 1'b1;
               stateNext   = RUN;
               issue       = (jobBus.botCount != '0) && fullOk;
            end
         end
         RUN: begin
            if (nextIndex == botCountQ) begin
               stateNext = DRAIN;
            end else begin
               issue = fullOk && capOk;
            end
         end
         DRAIN: begin
            if ((outstanding == '0) && !botReadEnableQ && !isBotValidQ) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, job capture, read issue and one-cycle-delayed bot presentation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         nextIndex      <= '0;
         botCountQ      <= '0;
         jobTopQ        <= '0;
         botReadEnableQ <= 1'b0;
         botReadAddrQ   <= '0;
         isBotValidQ    <= 1'b0;
         botIndexQ      <= '0;
         busyQ          <= 1'b0;
         doneQ          <= 1'b0;
      end else begin
         state <= stateNext;
         if (startAccept) begin
            jobTopQ   <= jobBus.jobTop;
            botCountQ <= jobBus.botCount;
            nextIndex <= issue ? (ADDR_WIDTH + 1)'(1) : '0;
         end else if (issue) begin
            nextIndex <= nextIndex + (ADDR_WIDTH + 1)'(1);
         end
         botReadEnableQ <= issue;
         if (issue) begin
            botReadAddrQ <= startAccept ? '0 : nextIndex[ADDR_WIDTH-1:0];
         end
         isBotValidQ <= botReadEnableQ;
         botIndexQ   <= botReadAddrQ;
         busyQ       <= (stateNext == RUN) || (stateNext == DRAIN);
         doneQ       <= (stateNext == DONE);
      end
   end

   job_result_accumulator #(
      .OUT_WIDTH (OUT_WIDTH)
   ) accumulator (
      .clk           (clk),
      .rst           (rst),
      .clear         (startAccept),
      .issue         (issue),
      .resultValid   (jobBus.resultValid),
      .summedData    (jobBus.summedData),
      .pcoeffCount   (jobBus.pcoeffCount),
      .outstanding   (outstanding),
      .totalSum      (jobBus.totalSum),
      .totalCount    (jobBus.totalCount),
      .protocolError (jobBus.protocolError)
   );

   assign jobBus.botReadEnable = botReadEnableQ;
   assign jobBus.botReadAddr   = botReadAddrQ;
   assign jobBus.isBotValid    = isBotValidQ;
   assign jobBus.botIndex      = botIndexQ;
   assign jobBus.top           = jobTopQ;
   assign jobBus.bot           = jobBus.botReadData;
   assign jobBus.busy          = busyQ;
   assign jobBus.done          = doneQ;

endmodule

// File: tb/tb_pipeline_job_sequencer.sv
// Directed bench for pipeline_job_sequencer with a bot memory model and a
// fixed-latency pack responder.
module tb_pipeline_job_sequencer;
   import pipeline_job_sequencer_pkg::*;

   localparam int unsigned AW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_job_sequencer_if #(.ADDR_WIDTH(AW)) jobBus ();

   pipeline_job_sequencer #(
      .ADDR_WIDTH      (AW),
      .FULL_THRESHOLD  (20),
      .MAX_OUTSTANDING (63)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .jobBus (jobBus)
   );

   int checks   = 0;
   int failures = 0;
   int enSeen   = 0;

   logic       autoRespond = 1'b0;
   logic       manualRv    = 1'b0;
   logic [9:0] respPipe    = '0;

   function automatic logic [127:0] memWord(input logic [AW-1:0] a);
      return {4{24'hB07000, a}};
   endfunction

   // Bot memory: one-cycle read latency.
   always @(posedge clk)
      jobBus.botReadData <= jobBus.botReadEnable ? memWord(jobBus.botReadAddr) : 128'h0;

   // Pack responder: one result about ten cycles after each presented bot.
   always @(posedge clk)
      respPipe <= {respPipe[8:0], jobBus.isBotValid & autoRespond};

   always_comb jobBus.resultValid = manualRv | respPipe[9];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (jobBus.botReadEnable === 1'b1) enSeen++;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n;
      n = 0;
      while (jobBus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 128'(jobBus.done), 128'd1);
   endtask

   task automatic checkIdle(input string tag);
      check({tag, "_busy"},  128'(jobBus.busy), 128'd0);
      check({tag, "_done"},  128'(jobBus.done), 128'd0);
      check({tag, "_en"},    128'(jobBus.botReadEnable), 128'd0);
      check({tag, "_valid"}, 128'(jobBus.isBotValid), 128'd0);
      check({tag, "_perr"},  128'(jobBus.protocolError), 128'd0);
      check({tag, "_sum"},   128'(jobBus.totalSum), 128'd0);
      check({tag, "_cnt"},   128'(jobBus.totalCount), 128'd0);
      check({tag, "_addr"},  128'(jobBus.botReadAddr), 128'd0);
      check({tag, "_idx"},   128'(jobBus.botIndex), 128'd0);
      check({tag, "_top"},   jobBus.top, 128'd0);
   endtask

   initial begin
      int fullPrev;
      int fullNow;
      int issued;
      int n;

      rst = 1'b1;
      jobBus.start       = 1'b0;
      jobBus.jobTop      = '0;
      jobBus.botCount    = '0;
      jobBus.maxFullness = '0;
      jobBus.summedData  = '0;
      jobBus.pcoeffCount = '0;
      tick();
      tick();
      checkIdle("reset");
      rst = 1'b0;
      tick();

      // Four bots, no backpressure.
      jobBus.summedData  = 40'd100;
      jobBus.pcoeffCount = 5'd24;
      autoRespond        = 1'b1;
      jobBus.jobTop      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      jobBus.botCount    = 9'd4;
      jobBus.start       = 1'b1;
      tick();
      jobBus.start = 1'b0;
      check("t1_top",   jobBus.top, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      check("t1_busy",  128'(jobBus.busy), 128'd1);
      check("t1_en0",   128'(jobBus.botReadEnable), 128'd1);
      check("t1_addr0", 128'(jobBus.botReadAddr), 128'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1_valid", 128'(jobBus.isBotValid), 128'd1);
         check("t1_idx",   128'(jobBus.botIndex), 128'(i));
         check("t1_bot",   jobBus.bot, memWord(AW'(i)));
         check("t1_en",    128'(jobBus.botReadEnable), (i < 3) ? 128'd1 : 128'd0);
         if (i < 3) check("t1_addr", 128'(jobBus.botReadAddr), 128'(i + 1));
      end
      tick();
      check("t1_valid_end", 128'(jobBus.isBotValid), 128'd0);
      waitDone("t1_done", 60);
      check("t1_sum",  128'(jobBus.totalSum), 128'd400);
      check("t1_cnt",  128'(jobBus.totalCount), 128'd96);
      check("t1_busy_done", 128'(jobBus.busy), 128'd0);
      jobBus.start = 1'b1;
      tick();
      jobBus.start = 1'b0;
      check("t1_done_pulse", 128'(jobBus.done), 128'd0);
      check("t1_start_in_done", 128'(jobBus.busy), 128'd0);
      check("t1_sum_hold", 128'(jobBus.totalSum), 128'd400);
      tick();
      check("t1_idle_busy", 128'(jobBus.busy), 128'd0);
      check("t1_cnt_hold", 128'(jobBus.totalCount), 128'd96);

      // Sixteen bots with a fullness stall.
      jobBus.summedData  = 40'd1;
      jobBus.pcoeffCount = 5'd1;
      jobBus.botCount    = 9'd16;
      jobBus.maxFullness = 5'd0;
      jobBus.start       = 1'b1;
      fullPrev = 0;
      issued   = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         jobBus.start = 1'b0;
         check("t2_en", 128'(jobBus.botReadEnable), (fullPrev < 20 && issued < 16) ? 128'd1 : 128'd0);
         if (jobBus.botReadEnable === 1'b1) begin
            check("t2_addr", 128'(jobBus.botReadAddr), 128'(issued));
            issued++;
         end
         fullNow = (i >= 3 && i <= 7) ? 20 : ((i == 8) ? 19 : 0);
         jobBus.maxFullness = 5'(fullNow);
         fullPrev = fullNow;
      end
      check("t2_issued", 128'(issued), 128'd16);
      waitDone("t2_done", 60);
      check("t2_sum", 128'(jobBus.totalSum), 128'd16);
      check("t2_cnt", 128'(jobBus.totalCount), 128'd16);
      tick();

      // Results withheld: issue caps at 63 outstanding.
      autoRespond        = 1'b0;
      jobBus.summedData  = 40'd7;
      jobBus.pcoeffCount = 5'd3;
      jobBus.botCount    = 9'd100;
      jobBus.start       = 1'b1;
      enSeen = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         jobBus.start = 1'b0;
      end
      check("t3_cap", 128'(enSeen), 128'd63);
      check("t3_en_stalled", 128'(jobBus.botReadEnable), 128'd0);
      manualRv = 1'b1;
      tick();
      manualRv = 1'b0;
      enSeen = 0;
      for (int i = 0; i < 10; i++) tick();
      check("t3_one_more", 128'(enSeen), 128'd1);
      check("t3_sum", 128'(jobBus.totalSum), 128'd7);
      check("t3_cnt", 128'(jobBus.totalCount), 128'd3);
      rst = 1'b1;
      tick();
      checkIdle("t3_rst");
      rst = 1'b0;
      tick();

      // Reset mid-RUN with five outstanding, then a clean job.
      jobBus.start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         jobBus.start = 1'b0;
      end
      check("t4_en",   128'(jobBus.botReadEnable), 128'd1);
      check("t4_addr", 128'(jobBus.botReadAddr), 128'd4);
      rst = 1'b1;
      tick();
      checkIdle("t4_rst");
      rst = 1'b0;
      tick();
      autoRespond        = 1'b1;
      jobBus.summedData  = 40'd50;
      jobBus.pcoeffCount = 5'd10;
      jobBus.botCount    = 9'd2;
      jobBus.start       = 1'b1;
      enSeen = 0;
      tick();
      jobBus.start = 1'b0;
      waitDone("t4_done", 60);
      check("t4_sum",   128'(jobBus.totalSum), 128'd100);
      check("t4_cnt",   128'(jobBus.totalCount), 128'd20);
      check("t4_reads", 128'(enSeen), 128'd2);
      check("t4_perr",  128'(jobBus.protocolError), 128'd0);
      tick();

      // Empty job.
      jobBus.botCount = 9'd0;
      jobBus.start    = 1'b1;
      enSeen = 0;
      tick();
      jobBus.start = 1'b0;
      n = 1;
      while (jobBus.done !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      check("t5_done",    128'(jobBus.done), 128'd1);
      check("t5_latency", 128'(n <= 3), 128'd1);
      check("t5_reads",   128'(enSeen), 128'd0);
      check("t5_sum",     128'(jobBus.totalSum), 128'd0);
      check("t5_cnt",     128'(jobBus.totalCount), 128'd0);
      tick();
      tick();

      // Stray result in IDLE, then start while busy is ignored.
      autoRespond       = 1'b0;
      jobBus.summedData = 40'd5;
      manualRv = 1'b1;
      tick();
      manualRv = 1'b0;
      check("t6_perr", 128'(jobBus.protocolError), 128'd1);
      check("t6_sum",  128'(jobBus.totalSum), 128'd0);
      autoRespond        = 1'b1;
      jobBus.summedData  = 40'd100;
      jobBus.pcoeffCount = 5'd24;
      jobBus.jobTop      = 128'hAAAA;
      jobBus.botCount    = 9'd3;
      jobBus.start       = 1'b1;
      enSeen = 0;
      tick();
      jobBus.start = 1'b0;
      tick();
      tick();
      jobBus.jobTop   = 128'hBBBB;
      jobBus.botCount = 9'd9;
      jobBus.start    = 1'b1;
      tick();
      jobBus.start = 1'b0;
      check("t6_top",  jobBus.top, 128'hAAAA);
      check("t6_busy", 128'(jobBus.busy), 128'd1);
      waitDone("t6_done", 60);
      check("t6_reads",       128'(enSeen), 128'd3);
      check("t6_sum_done",    128'(jobBus.totalSum), 128'd300);
      check("t6_cnt_done",    128'(jobBus.totalCount), 128'd72);
      check("t6_perr_sticky", 128'(jobBus.protocolError), 128'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
